// File: rtl/uart_pkg.sv
// Shared constants, state encoding and prescaler helper for the UART receiver.
package uart_pkg;

  localparam int OSR        = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OSR) / 2) / (baud * OSR);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 4-entry first-word-fall-through byte FIFO with an overrun indication.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ovf
);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;

  assign w_full  = (r_count == 3'(FIFO_DEPTH));
  assign w_pop   = i_pop && (r_count != 3'd0);
  // A pop in the same cycle frees the slot the push needs.
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_ovf   = i_push && w_full && !w_pop;
  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != 3'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, 16x prescaler, framing FSM, sticky error flags
// and a small FWFT FIFO toward the host logic.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DOUT,
  output logic       VALID,
  input  logic       RD,
  output logic       FERR,
  output logic       OVF,
  input  logic       ERRCLR
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_tc;
  rx_state_e     r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_s7;
  logic          r_s8;
  logic          r_ferr;
  logic          r_ovf;

  logic w_tick;
  logic w_fall;
  logic w_decide;
  logic w_maj;
  logic w_push;
  logic w_ferr_set;
  logic w_ovf_set;

  assign w_tick     = (r_presc == '0);
  assign w_fall     = r_rx_prev && !r_sync2;
  assign w_decide   = w_tick && (r_tc == 4'd9);
  assign w_maj      = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_push     = w_decide && (r_state == ST_STOP) && w_maj;
  assign w_ferr_set = w_decide && (r_state == ST_STOP) && !w_maj;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= RXD;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_tc      <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_s7      <= 1'b0;
      r_s8      <= 1'b0;
    end else begin
      r_presc <= w_tick ? PW'(DIV - 1) : r_presc - 1'b1;
      if (w_tick) begin
        r_tc <= r_tc + 4'd1;
        if (r_tc == 4'd7) r_s7 <= r_sync2;
        if (r_tc == 4'd8) r_s8 <= r_sync2;
      end
      case (r_state)
        ST_IDLE: begin
          // Realign the bit clock to the start edge.
          if (w_fall) begin
            r_state <= ST_START;
            r_tc    <= 4'd0;
            r_presc <= '0;
          end
        end
        ST_START: begin
          if (w_decide && w_maj) begin
            r_state <= ST_IDLE;
          end else if (w_tick && r_tc == 4'd15) begin
            r_state   <= ST_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
          if (w_tick && r_tc == 4'd15) begin
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (w_decide) r_state <= w_maj ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (r_sync2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A set in the same cycle as ERRCLR wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_ferr_set)  r_ferr <= 1'b1;
      else if (ERRCLR) r_ferr <= 1'b0;
      if (w_ovf_set)   r_ovf  <= 1'b1;
      else if (ERRCLR) r_ovf  <= 1'b0;
    end
  end

  uart_rx_fifo u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (RD),
    .o_data  (DOUT),
    .o_valid (VALID),
    .o_ovf   (w_ovf_set)
  );

  assign FERR = r_ferr;
  assign OVF  = r_ovf;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board's UART link, the receive-side counterpart of the MicroBlaze MCS `UART_txd` path. It turns the asynchronous 8N1 `RXD` pin into bytes held in a 4-entry first-word-fall-through FIFO that the host logic pops with a `RD` strobe. Framing errors and overruns are reported as sticky flags. It sits at the top level next to the MCS instance, on the 50 MHz `CLK` domain.

## Interface
- `CLK_HZ`, 50_000_000: frequency of `CLK` in Hz.
- `BAUD`, 9600: line rate in bits per second.
- `DIV`, round(`CLK_HZ`/(`BAUD`*16)) = 326: prescaler period in clocks per 16x tick. It may be overridden directly in simulation.
- `CLK`  in  1  system clock, 50 MHz. This block uses one clock.
- `RST`  in  1  reset, synchronous and active-high.
- `RXD`  in  1  asynchronous serial input. Idle level is high.
- `DOUT`  out  8  byte at the FIFO head. Valid only while `VALID`=1.
- `VALID`  out  1  FIFO not empty.
- `RD`  in  1  pop strobe. It pops one byte per cycle while `VALID`=1 and is ignored when `VALID`=0.
- `FERR`  out  1  sticky framing error.
- `OVF`  out  1  sticky overrun.
- `ERRCLR`  in  1  one-cycle pulse that clears `FERR` and `OVF`.

## Operation
- **Synchronizer:** `RXD` passes through a 2-FF synchronizer with both flops reset to 1. All logic downstream uses the synchronized signal `rx_s`.
- **Prescaler:** counts `DIV`-1 down to 0 and emits a one-cycle `tick` at 0. It free-runs and is reset by `RST` only.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** a falling edge of `rx_s` moves the FSM to START, clears the tick counter `tc` (4 bits) and clears the prescaler.
- **Sampling:** every bit period is 16 ticks. Samples are taken at `tc` = 7, 8 and 9, and the bit value is the majority of the three samples. The bit is decided at `tc`=9.
- **START:** if the majority is 1, this is a false start and the FSM returns to IDLE. Otherwise it goes to DATA when `tc` wraps from 15 to 0.
- **DATA:** receives 8 bits LSB first into a shift register, with bit index 0..7. After bit 7 has wrapped, the FSM goes to STOP.
- **STOP, majority 1:** the byte is pushed to the FIFO at the decision cycle (`tc`=9). The FSM goes to IDLE in the same cycle, so a following start edge is accepted half a bit early.
- **STOP, majority 0:** the byte is discarded, `FERR` is set and the FSM goes to BREAK.
- **BREAK:** waits for `rx_s`=1, then goes to IDLE. A held-low line therefore produces exactly one `FERR` event and no bytes.
- **FIFO:** 4 entries with 2-bit read and write pointers plus a 3-bit count.
  - Push while full and not popping: the byte is dropped and `OVF` is set.
  - Push and pop in the same cycle while full: both succeed, `OVF` is unchanged and the count stays 4.
  - Push and pop in the same cycle while empty: impossible, because a pop requires `VALID`=1.
- **Error flags:** `ERRCLR` has priority below a same-cycle set, so the flag stays 1.

## Timing
- **Reset values:** `DOUT`=0x00, `VALID`=0, `FERR`=0, `OVF`=0. The FSM is in IDLE, the FIFO is empty, the prescaler and `tc` are 0, and the shift register is 0.
- **Reset mid-frame:** the partial byte is lost. After reset the receiver waits in IDLE for the next falling edge.
- **Start detection:** the falling edge is seen 2 cycles after the `RXD` edge because of the synchronizer.
- **`VALID` latency:** `VALID` rises 1 cycle after the push. That is about 9.56 bit times after the start edge on `RXD`, plus 3 cycles.
- **`DOUT` on pop:** `DOUT` updates the cycle after an `RD` pop. `VALID` falls in the same cycle if the FIFO became empty.
- **Tolerance:** the receiver tolerates ±3% baud mismatch between transmitter and receiver.

## Structure
- **Package `uart_pkg`:**
  - constant `OSR`=16;
  - a function computing `DIV` from `CLK_HZ` and `BAUD` with rounding;
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK);
  - the FIFO depth constant 4.
- **Sub-module `uart_rx_fifo`:** a natural split. It holds the 4x8 storage, the pointers and count, the push/pop logic and the overflow pulse. `uart_rx` holds the synchronizer, prescaler, FSM and sticky flags.

## Test plan
All scenarios override `DIV`=4, giving 64 clocks per bit.
- **Good frame:** send 0x55 as 8N1 → `VALID`=1 with `DOUT`=0x55, `FERR`=0; `RD` pulse → `VALID`=0.
- **False start:** drive `RXD` low for 20 clocks, then high → no push, `VALID`=0, FSM back in IDLE. Then send 0xC3 → `DOUT`=0xC3.
- **Framing error and break:**
  - Send 0xA3 with a low stop bit, then hold `RXD` low for 20 bit times → no `VALID`, `FERR`=1 set once.
  - Release the line and send 0x3C → `DOUT`=0x3C and `FERR` still 1.
  - Pulse `ERRCLR` → `FERR`=0.
- **Overrun:** send 0x01..0x05 back-to-back with no `RD` → `OVF`=1. Reading gives 0x01, 0x02, 0x03, 0x04, then `VALID`=0; 0x05 is lost.
- **Full FIFO with same-cycle pop:** fill the FIFO with 0x01..0x04, then pulse `RD` in the exact push cycle of 0x05 → `OVF`=0. Reading gives 0x02..0x05.
- **Reset mid-frame:** assert `RST` for 1 cycle during bit 4 of 0x9E → all outputs at reset values. The next frame, 0x7F, is received correctly.
